// File: rtl/ef_cart_mapper_pkg.sv
// ef_cart_mapper_pkg
// Shared definitions for the EasyFlash cartridge mapper:
//   - bit positions of the $DE02 control register {LED, M, X, G}
//   - ctrl_t, the packed form of that control register
//   - register selection by bus_addr[1] ($DE00 bank / $DE02 control)
//   - rd_src_t, the source that drives cart_dout during a read
//   - decode_ctrl(), which turns a $DE02 write byte into a ctrl_t
package ef_cart_mapper_pkg;

    localparam int CTRL_LED_BIT = 7;
    localparam int CTRL_M_BIT   = 2;
    localparam int CTRL_X_BIT   = 1;
    localparam int CTRL_G_BIT   = 0;

    // Value of bus_addr[1] that selects each register. The whole $DExx
    // page mirrors these two registers.
    localparam logic REG_BANK = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    typedef struct packed {
        logic led;
        logic m;
        logic x;
        logic g;
    } ctrl_t;

    typedef enum logic [1:0] {
        RD_NONE  = 2'd0,
        RD_RAM   = 2'd1,
        RD_FLASH = 2'd2
    } rd_src_t;

    // din[6:3] carry no function and are dropped.
    function automatic ctrl_t decode_ctrl(input logic [7:0] din);
        ctrl_t c;
        c.led = din[CTRL_LED_BIT];
        c.m   = din[CTRL_M_BIT];
        c.x   = din[CTRL_X_BIT];
        c.g   = din[CTRL_G_BIT];
        return c;
    endfunction

endpackage

// File: rtl/ef_cart_mapper_if.sv
// ef_cart_mapper_if
// Qualified C64 expansion-port cycle as seen by the mapper.
//   bus_stb            1-cycle pulse; all other request fields are stable during it
//   bus_addr/bus_din   CPU/VIC address and write data
//   bus_rw             1 = read, 0 = write
//   roml_n/romh_n      ROML / ROMH selects (active low)
//   io1_n/io2_n        $DExx / $DFxx selects (active low)
//   cart_dout/cart_oe  cartridge read data and its valid/drive flag
// Modport master is the C64 side, modport slave is the mapper.
interface ef_cart_mapper_if;

    logic        bus_stb;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_rw;
    logic        roml_n;
    logic        romh_n;
    logic        io1_n;
    logic        io2_n;
    logic [7:0]  cart_dout;
    logic        cart_oe;

    modport master (
        output bus_stb, bus_addr, bus_din, bus_rw,
        output roml_n, romh_n, io1_n, io2_n,
        input  cart_dout, cart_oe
    );

    modport slave (
        input  bus_stb, bus_addr, bus_din, bus_rw,
        input  roml_n, romh_n, io1_n, io2_n,
        output cart_dout, cart_oe
    );

endinterface

// File: rtl/ef_cart_mapper_io_ram.sv
// ef_cart_mapper_io_ram
// Single-port synchronous RAM behind the $DFxx window. It has no reset, so
// its contents survive a cartridge reset. The port is write-first: a write
// also presents the new byte on q.
//   clk   system clock
//   en    access enable; q only updates on an enabled cycle
//   we    write enable (qualified by en)
//   addr  byte address
//   din   write data
//   q     read data, one clk after the enabled cycle
module ef_cart_mapper_io_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    q
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                q         <= din;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ef_cart_mapper.sv
// ef_cart_mapper
// EasyFlash cartridge mapper, placed directly in front of the ez_rom flash
// emulator. It decodes qualified C64 cycles into writes to the bank and
// control registers and accesses to the 256 B I/O RAM. It builds the flash
// address and a single-clock flash strobe, drives EXROM/GAME/LED, and
// returns read data to the bus.
//   clk, reset_n   system clock; asynchronous active-low reset
//   bus            C64 cycle interface (slave modport)
//   boot_jumper    1 = GAME is asserted while ctrl.M = 0
//   exrom_n/game_n registered cartridge mode lines
//   led            registered cartridge LED
//   fl_ce/fl_we    flash strobe (1 clk) and write flag
//   fl_addr        {chip, bank, A[12:0]}
//   fl_din/fl_dout flash write data / flash read data
module ef_cart_mapper
    import ef_cart_mapper_pkg::*;
#(
    parameter int BANK_BITS = 6,
    parameter int RAM_AW    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ef_cart_mapper_if.slave        bus,
    input  logic                   boot_jumper,
    output logic                   exrom_n,
    output logic                   game_n,
    output logic                   led,
    output logic                   fl_ce,
    output logic                   fl_we,
    output logic [19:0]            fl_addr,
    output logic [7:0]             fl_din,
    input  logic [7:0]             fl_dout
);

    logic [BANK_BITS-1:0] bank, bank_next;
    ctrl_t                ctrl, ctrl_next;
    rd_src_t              rd_src, rd_src_next;
    logic                 ce_next, we_next;
    logic [19:0]          addr_next;
    logic [7:0]           din_next;
    logic [5:0]           bank_ext;
    logic                 rom_sel, io1_sel, io2_sel;
    logic                 ram_en, ram_we;
    logic [7:0]           ram_q;
    logic                 unused_addr_bits;

    assign rom_sel = ~bus.roml_n | ~bus.romh_n;
    assign io1_sel = ~bus.io1_n;
    assign io2_sel = ~bus.io2_n;
    assign ram_en  = bus.bus_stb & io2_sel;
    assign ram_we  = ram_en & ~bus.bus_rw;

    // The C64 address lines above A12 are already encoded in the selects.
    assign unused_addr_bits = &{1'b0, bus.bus_addr[15:13]};

    // A narrower bank register still occupies the full 6-bit bank field of
    // the flash address, with the upper bits held at zero.
    always_comb begin
        bank_ext                 = '0;
        bank_ext[BANK_BITS-1:0]  = bank;
    end

    // Next-state decode. Nothing changes outside a strobe except fl_ce
    // falling back to 0. The flash address and data are captured on every
    // strobe and then held. ROMH takes priority over ROML in the chip bit.
    always_comb begin
        bank_next   = bank;
        ctrl_next   = ctrl;
        rd_src_next = rd_src;
        ce_next     = 1'b0;
        we_next     = fl_we;
        addr_next   = fl_addr;
        din_next    = fl_din;
        if (bus.bus_stb) begin
            ce_next     = rom_sel;
            we_next     = rom_sel & ~bus.bus_rw;
            addr_next   = {~bus.romh_n, bank_ext, bus.bus_addr[12:0]};
            din_next    = bus.bus_din;
            rd_src_next = RD_NONE;
            if (bus.bus_rw) begin
                if (rom_sel) begin
                    rd_src_next = RD_FLASH;
                end else if (io2_sel) begin
                    rd_src_next = RD_RAM;
                end
            end else if (io1_sel) begin
                if (bus.bus_addr[1] == REG_BANK) begin
                    bank_next = bus.bus_din[BANK_BITS-1:0];
                end else begin
                    ctrl_next = decode_ctrl(bus.bus_din);
                end
            end
        end
    end

    // The mode lines are computed from the next control value, so a $DE02
    // write reaches the pins on the same clk as the register itself. The
    // reset value of game_n follows the boot jumper.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank    <= '0;
            ctrl    <= '0;
            rd_src  <= RD_NONE;
            fl_ce   <= 1'b0;
            fl_we   <= 1'b0;
            fl_addr <= '0;
            fl_din  <= '0;
            exrom_n <= 1'b1;
            game_n  <= ~boot_jumper;
            led     <= 1'b0;
        end else begin
            bank    <= bank_next;
            ctrl    <= ctrl_next;
            rd_src  <= rd_src_next;
            fl_ce   <= ce_next;
            fl_we   <= we_next;
            fl_addr <= addr_next;
            fl_din  <= din_next;
            exrom_n <= ~ctrl_next.x;
            game_n  <= ctrl_next.m ? ~ctrl_next.g : ~boot_jumper;
            led     <= ctrl_next.led;
        end
    end

    // Flash data is passed through live, so status/toggle bytes from a busy
    // flash reach the bus unchanged.
    assign bus.cart_oe   = (rd_src != RD_NONE);
    assign bus.cart_dout = (rd_src == RD_RAM)   ? ram_q   :
                           (rd_src == RD_FLASH) ? fl_dout : 8'h00;

    ef_cart_mapper_io_ram #(
        .AW (RAM_AW)
    ) u_io_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (bus.bus_addr[RAM_AW-1:0]),
        .din  (bus.bus_din),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_ef_cart_mapper.sv
// tb_ef_cart_mapper
// Directed-vector bench for ef_cart_mapper. It drives C64 cycles through
// the bus interface and compares outputs against hand-computed values.
module tb_ef_cart_mapper;

    logic        clk;
    logic        reset_n;
    logic        boot_jumper;
    logic        exrom_n;
    logic        game_n;
    logic        led;
    logic        fl_ce;
    logic        fl_we;
    logic [19:0] fl_addr;
    logic [7:0]  fl_din;
    logic [7:0]  fl_dout;

    int compare_count;
    int mismatch_count;

    ef_cart_mapper_if bus_if ();

    ef_cart_mapper #(
        .BANK_BITS (6),
        .RAM_AW    (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .boot_jumper (boot_jumper),
        .exrom_n     (exrom_n),
        .game_n      (game_n),
        .led         (led),
        .fl_ce       (fl_ce),
        .fl_we       (fl_we),
        .fl_addr     (fl_addr),
        .fl_din      (fl_din),
        .fl_dout     (fl_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one C64 cycle with the selects decoded from the address. It
    // returns 1 ns after the clock edge that samples the strobe.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                 input logic rw);
        @(negedge clk);
        bus_if.bus_addr = a;
        bus_if.bus_din  = d;
        bus_if.bus_rw   = rw;
        bus_if.roml_n   = !(a[15:13] == 3'b100);
        bus_if.romh_n   = !(a[15:13] == 3'b101 || a[15:13] == 3'b111);
        bus_if.io1_n    = !(a[15:8] == 8'hDE);
        bus_if.io2_n    = !(a[15:8] == 8'hDF);
        bus_if.bus_stb  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_stb  = 1'b0;
    endtask

    task automatic nextClock();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] unlock_addr [4];
    logic [7:0]  unlock_data [4];
    logic [10:0] unlock_low  [4];

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        unlock_addr = '{16'h8555, 16'h82AA, 16'h8555, 16'h8000};
        unlock_data = '{8'hAA, 8'h55, 8'hA0, 8'h3C};
        unlock_low  = '{11'h555, 11'h2AA, 11'h555, 11'h000};

        reset_n         = 1'b0;
        boot_jumper     = 1'b1;
        fl_dout         = 8'h5A;
        bus_if.bus_stb  = 1'b0;
        bus_if.bus_addr = 16'h0000;
        bus_if.bus_din  = 8'h00;
        bus_if.bus_rw   = 1'b1;
        bus_if.roml_n   = 1'b1;
        bus_if.romh_n   = 1'b1;
        bus_if.io1_n    = 1'b1;
        bus_if.io2_n    = 1'b1;

        // Reset state
        #22;
        checkOutput("rst_exrom_n", exrom_n, 1'b1);
        checkOutput("rst_game_n", game_n, 1'b0);
        checkOutput("rst_led", led, 1'b0);
        checkOutput("rst_fl_ce", fl_ce, 1'b0);
        checkOutput("rst_fl_we", fl_we, 1'b0);
        checkOutput("rst_cart_oe", bus_if.cart_oe, 1'b0);
        checkOutput("rst_cart_dout", bus_if.cart_dout, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // ROMH read at $E000 with bank 0
        applyStimulus(16'hE000, 8'h00, 1'b1);
        checkOutput("romh_fl_addr", fl_addr, 20'h80000);
        checkOutput("romh_fl_ce", fl_ce, 1'b1);
        checkOutput("romh_fl_we", fl_we, 1'b0);
        checkOutput("romh_cart_oe", bus_if.cart_oe, 1'b1);
        checkOutput("romh_cart_dout", bus_if.cart_dout, 8'h5A);
        fl_dout = 8'h40;
        #1;
        checkOutput("romh_status_pass", bus_if.cart_dout, 8'h40);
        nextClock();
        checkOutput("romh_fl_ce_fall", fl_ce, 1'b0);
        checkOutput("romh_fl_addr_hold", fl_addr, 20'h80000);

        // Bank register, its mirrors, and bank wrap
        applyStimulus(16'hDE00, 8'h05, 1'b0);
        checkOutput("io1_wr_no_ce", fl_ce, 1'b0);
        applyStimulus(16'h8123, 8'h00, 1'b1);
        checkOutput("bank5_fl_addr", fl_addr, 20'h0A123);
        checkOutput("bank5_fl_we", fl_we, 1'b0);
        applyStimulus(16'hDE00, 8'hFF, 1'b0);
        applyStimulus(16'h8000, 8'h00, 1'b1);
        checkOutput("bank_wrap_bits", fl_addr[18:13], 6'h3F);
        applyStimulus(16'hDE41, 8'h03, 1'b0);
        applyStimulus(16'h8000, 8'h00, 1'b1);
        checkOutput("bank_mirror_addr", fl_addr, 20'h06000);

        // Control register
        applyStimulus(16'hDE02, 8'h87, 1'b0);
        checkOutput("ctrl87_led", led, 1'b1);
        checkOutput("ctrl87_exrom_n", exrom_n, 1'b0);
        checkOutput("ctrl87_game_n", game_n, 1'b0);
        applyStimulus(16'hDE02, 8'h04, 1'b0);
        checkOutput("ctrl04_game_n", game_n, 1'b1);
        checkOutput("ctrl04_exrom_n", exrom_n, 1'b1);
        checkOutput("ctrl04_led", led, 1'b0);
        applyStimulus(16'hDE07, 8'h00, 1'b0);
        checkOutput("ctrl_mirror_game_n", game_n, 1'b0);
        boot_jumper = 1'b0;
        nextClock();
        checkOutput("boot_off_game_n", game_n, 1'b1);
        boot_jumper = 1'b1;
        nextClock();

        // A write with no strobe has no side effects
        @(negedge clk);
        bus_if.bus_addr = 16'hDE02;
        bus_if.bus_din  = 8'h83;
        bus_if.bus_rw   = 1'b0;
        bus_if.io1_n    = 1'b0;
        bus_if.roml_n   = 1'b1;
        bus_if.romh_n   = 1'b1;
        bus_if.io2_n    = 1'b1;
        nextClock();
        nextClock();
        checkOutput("nostb_led", led, 1'b0);
        checkOutput("nostb_exrom_n", exrom_n, 1'b1);

        // I/O2 RAM, and an open-bus read at $DE00
        applyStimulus(16'hDF10, 8'hA5, 1'b0);
        applyStimulus(16'hDF10, 8'h00, 1'b1);
        checkOutput("ram_cart_oe", bus_if.cart_oe, 1'b1);
        checkOutput("ram_cart_dout", bus_if.cart_dout, 8'hA5);
        checkOutput("ram_no_fl_ce", fl_ce, 1'b0);
        applyStimulus(16'hDE00, 8'h00, 1'b1);
        checkOutput("io1_rd_cart_oe", bus_if.cart_oe, 1'b0);

        // Flash program command sequence
        for (int i = 0; i < 4; i++) begin
            applyStimulus(unlock_addr[i], unlock_data[i], 1'b0);
            checkOutput($sformatf("unlock%0d_fl_ce", i), fl_ce, 1'b1);
            checkOutput($sformatf("unlock%0d_fl_we", i), fl_we, 1'b1);
            checkOutput($sformatf("unlock%0d_addr", i), fl_addr[10:0], unlock_low[i]);
            checkOutput($sformatf("unlock%0d_din", i), fl_din, unlock_data[i]);
            nextClock();
            checkOutput($sformatf("unlock%0d_ce_fall", i), fl_ce, 1'b0);
        end

        // Asynchronous reset in the middle of a ROML read
        applyStimulus(16'hDE02, 8'h87, 1'b0);
        applyStimulus(16'h8000, 8'h00, 1'b1);
        checkOutput("pre_rst_cart_oe", bus_if.cart_oe, 1'b1);
        checkOutput("pre_rst_fl_ce", fl_ce, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_cart_oe", bus_if.cart_oe, 1'b0);
        checkOutput("async_rst_fl_ce", fl_ce, 1'b0);
        checkOutput("async_rst_led", led, 1'b0);
        checkOutput("async_rst_exrom_n", exrom_n, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(16'h9FFF, 8'h00, 1'b1);
        checkOutput("post_rst_bank0", fl_addr, 20'h01FFF);
        applyStimulus(16'hDF10, 8'h00, 1'b1);
        checkOutput("post_rst_ram", bus_if.cart_dout, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compare_count, mismatch_count);
        $finish;
    end

endmodule
